// File: rtl/uart_apb_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_apb_fifo_if
// Description : APB3 slave bus bundle for the uart_apb_fifo peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_apb_fifo_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [4:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/uart_apb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_apb_fifo
// Description : APB3 UART with TX/RX FIFOs, 16x oversampling, optional parity.
//               Define UART_APB_FIFO_IRQ_EN to build the IRQEN/IRQ logic.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_apb_fifo #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [12:0] RST_BAUD   = 13'd0
) (
    input  wire logic      PCLK,
    input  wire logic      PRESETN,
    uart_apb_fifo_if.slave apb,
    input  wire logic      RX,
    output logic           TX,
    output logic           TXRDY,
    output logic           RXRDY,
    output logic           IRQ
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [2:0] c_REG_TXDATA = 3'd0;
    localparam logic [2:0] c_REG_RXDATA = 3'd1;
    localparam logic [2:0] c_REG_BAUDLO = 3'd2;
    localparam logic [2:0] c_REG_CTRL   = 3'd3;
    localparam logic [2:0] c_REG_STATUS = 3'd4;
    localparam logic [2:0] c_REG_LEVEL  = 3'd5;
    localparam logic [2:0] c_REG_IRQEN  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [12:0] r_div, r_bcnt;
    logic        r_pen, r_odd;
    logic        r_tx_ovf, r_frm_err, r_ovf, r_par_err;
    logic [7:0]  r_prdata;
    logic [7:0]  r_tx_mem [FIFO_DEPTH];
    logic [7:0]  r_rx_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [c_CW-1:0] r_tx_cnt, r_rx_cnt;
    state_t      r_tx_st, w_tx_st_n, r_rx_st, w_rx_st_n;
    logic [3:0]  r_tx_tc, w_tx_tc_n, r_rx_tc, w_rx_tc_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n, r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_tx_byte, r_rx_sh, w_rx_sh_n;
    logic [1:0]  r_rx_sync;
    logic        r_rx_prev;

    logic        w_wr, w_setup_rd, w_acc_rd, w_stat_wr, w_div_wr, w_tick;
    logic [2:0]  w_reg;
    logic        w_tx_full, w_tx_empty, w_tx_pop, w_tx_push, w_tx_done;
    logic        w_rx_full, w_rx_empty, w_rx_pop, w_rx_push, w_rx_push_req;
    logic        w_set_perr, w_set_frm, w_rx_in, w_fall;
    logic [7:0]  w_status, w_level, w_rdata, w_irqen_rd;
    logic [8:0]  w_rx_cnt9;
    logic        w_unused;

    assign w_reg      = apb.PADDR[4:2];
    assign w_unused   = ^apb.PADDR[1:0];
    assign w_wr       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign w_setup_rd = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
    assign w_acc_rd   = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign w_stat_wr  = w_wr && (w_reg == c_REG_STATUS);
    assign w_div_wr   = w_wr && ((w_reg == c_REG_BAUDLO) || (w_reg == c_REG_CTRL));
    assign w_tick     = (r_bcnt == r_div);

    assign w_tx_full  = (r_tx_cnt == c_CW'(FIFO_DEPTH));
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_CW'(FIFO_DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_tx_done  = w_tx_empty && (r_tx_st == S_IDLE);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_tx_push  = w_wr && (w_reg == c_REG_TXDATA) && (!w_tx_full || w_tx_pop);
    assign w_rx_pop   = w_acc_rd && (w_reg == c_REG_RXDATA) && !w_rx_empty;
    assign w_rx_push  = w_rx_push_req && (!w_rx_full || w_rx_pop);

    assign TXRDY       = ~w_tx_full;
    assign RXRDY       = ~w_rx_empty;
    assign apb.PRDATA  = r_prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

    assign w_rx_cnt9 = 9'(r_rx_cnt);
    assign w_level   = (w_rx_cnt9 > 9'd255) ? 8'hFF : w_rx_cnt9[7:0];
    assign w_status  = {1'b0, r_tx_ovf, w_tx_done, r_frm_err, r_ovf, r_par_err, RXRDY, TXRDY};

    always_comb begin
        w_rdata = 8'h00;
        case (w_reg)
            c_REG_RXDATA: w_rdata = r_rx_mem[r_rx_rp];
            c_REG_BAUDLO: w_rdata = r_div[7:0];
            c_REG_CTRL:   w_rdata = {r_div[12:8], 1'b0, r_odd, r_pen};
            c_REG_STATUS: w_rdata = w_status;
            c_REG_LEVEL:  w_rdata = w_level;
            c_REG_IRQEN:  w_rdata = w_irqen_rd;
            default:      w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_div     <= RST_BAUD;
            r_bcnt    <= 13'd0;
            r_pen     <= 1'b0;
            r_odd     <= 1'b0;
            r_tx_ovf  <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf     <= 1'b0;
            r_par_err <= 1'b0;
            r_prdata  <= 8'h00;
        end else begin
            if (w_wr && (w_reg == c_REG_BAUDLO)) r_div[7:0] <= apb.PWDATA;
            if (w_wr && (w_reg == c_REG_CTRL)) begin
                r_div[12:8] <= apb.PWDATA[7:3];
                r_odd       <= apb.PWDATA[1];
                r_pen       <= apb.PWDATA[0];
            end
            if (w_div_wr || w_tick) r_bcnt <= 13'd0;
            else                    r_bcnt <= r_bcnt + 13'd1;
            // Set wins over a simultaneous write-1-to-clear.
            r_tx_ovf  <= (r_tx_ovf  & ~(w_stat_wr & apb.PWDATA[6]))
                       | (w_wr && (w_reg == c_REG_TXDATA) && w_tx_full && !w_tx_pop);
            r_frm_err <= (r_frm_err & ~(w_stat_wr & apb.PWDATA[4])) | w_set_frm;
            r_ovf     <= (r_ovf     & ~(w_stat_wr & apb.PWDATA[3]))
                       | (w_rx_push_req && w_rx_full && !w_rx_pop);
            r_par_err <= (r_par_err & ~(w_stat_wr & apb.PWDATA[2])) | w_set_perr;
            if (w_setup_rd && !((w_reg == c_REG_RXDATA) && w_rx_empty)) r_prdata <= w_rdata;
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= apb.PWDATA;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
            r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + c_AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_AW'(1);
            if (w_rx_push) r_rx_wp <= r_rx_wp + c_AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_AW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + c_CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - c_CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + c_CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - c_CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_tx_st   <= S_IDLE;
            r_tx_tc   <= 4'd0;
            r_tx_bit  <= 3'd0;
            r_tx_byte <= 8'h00;
            r_rx_st   <= S_IDLE;
            r_rx_tc   <= 4'd0;
            r_rx_bit  <= 3'd0;
            r_rx_sh   <= 8'h00;
            // Cleared to 0 so a line already low at release is not seen as a start edge.
            r_rx_sync <= 2'b00;
            r_rx_prev <= 1'b0;
        end else begin
            r_tx_st   <= w_tx_st_n;
            r_tx_tc   <= w_tx_tc_n;
            r_tx_bit  <= w_tx_bit_n;
            if (w_tx_pop) r_tx_byte <= r_tx_mem[r_tx_rp];
            r_rx_st   <= w_rx_st_n;
            r_rx_tc   <= w_rx_tc_n;
            r_rx_bit  <= w_rx_bit_n;
            r_rx_sh   <= w_rx_sh_n;
            r_rx_sync <= {r_rx_sync[0], RX};
            r_rx_prev <= r_rx_sync[1];
        end
    end

    always_comb begin
        w_tx_st_n  = r_tx_st;
        w_tx_tc_n  = r_tx_tc;
        w_tx_bit_n = r_tx_bit;
        w_tx_pop   = 1'b0;
        if (r_tx_st == S_IDLE) begin
            w_tx_tc_n = 4'd0;
            if (w_tick && !w_tx_empty) begin
                w_tx_pop  = 1'b1;
                w_tx_st_n = S_START;
            end
        end else if (w_tick) begin
            w_tx_tc_n = r_tx_tc + 4'd1;
            if (r_tx_tc == 4'd15) begin
                case (r_tx_st)
                    S_START: begin
                        w_tx_st_n  = S_DATA;
                        w_tx_bit_n = 3'd0;
                    end
                    S_DATA: begin
                        if (r_tx_bit == 3'd7) w_tx_st_n = r_pen ? S_PARITY : S_STOP;
                        else                  w_tx_bit_n = r_tx_bit + 3'd1;
                    end
                    S_PARITY: w_tx_st_n = S_STOP;
                    default: begin
                        w_tx_pop  = !w_tx_empty;
                        w_tx_st_n = w_tx_empty ? S_IDLE : S_START;
                    end
                endcase
            end
        end
    end

    always_comb begin
        TX = 1'b1;
        case (r_tx_st)
            S_START:  TX = 1'b0;
            S_DATA:   TX = r_tx_byte[r_tx_bit];
            S_PARITY: TX = ^r_tx_byte ^ r_odd;
            default:  TX = 1'b1;
        endcase
    end

    assign w_rx_in = r_rx_sync[1];
    assign w_fall  = r_rx_prev & ~r_rx_sync[1];

    always_comb begin
        w_rx_st_n     = r_rx_st;
        w_rx_tc_n     = r_rx_tc;
        w_rx_bit_n    = r_rx_bit;
        w_rx_sh_n     = r_rx_sh;
        w_rx_push_req = 1'b0;
        w_set_perr    = 1'b0;
        w_set_frm     = 1'b0;
        case (r_rx_st)
            S_IDLE: begin
                w_rx_tc_n = 4'd0;
                if (w_fall) w_rx_st_n = S_START;
            end
            S_START: if (w_tick) begin
                w_rx_tc_n = r_rx_tc + 4'd1;
                // Eighth tick is mid start bit; a high line here is a glitch.
                if (r_rx_tc == 4'd7) begin
                    w_rx_tc_n  = 4'd0;
                    w_rx_bit_n = 3'd0;
                    w_rx_st_n  = w_rx_in ? S_IDLE : S_DATA;
                end
            end
            default: if (w_tick) begin
                w_rx_tc_n = r_rx_tc + 4'd1;
                if (r_rx_tc == 4'd15) begin
                    case (r_rx_st)
                        S_DATA: begin
                            w_rx_sh_n = {w_rx_in, r_rx_sh[7:1]};
                            if (r_rx_bit == 3'd7) w_rx_st_n = r_pen ? S_PARITY : S_STOP;
                            else                  w_rx_bit_n = r_rx_bit + 3'd1;
                        end
                        S_PARITY: begin
                            w_set_perr = (w_rx_in != (^r_rx_sh ^ r_odd));
                            w_rx_st_n  = S_STOP;
                        end
                        default: begin
                            w_rx_push_req = 1'b1;
                            w_set_frm     = ~w_rx_in;
                            w_rx_st_n     = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

`ifdef UART_APB_FIFO_IRQ_EN
    logic [3:0] r_irqen;
    logic       r_irq;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_irqen <= 4'd0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr && (w_reg == c_REG_IRQEN)) r_irqen <= apb.PWDATA[3:0];
            r_irq <= |(r_irqen & {r_frm_err, r_ovf, w_tx_done, RXRDY});
        end
    end

    assign w_irqen_rd = {4'b0000, r_irqen};
    assign IRQ        = r_irq;
`else
    assign w_irqen_rd = 8'h00;
    assign IRQ        = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_uart_apb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_apb_fifo
// Description : Directed self-checking bench for uart_apb_fifo (FIFO_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_apb_fifo;
    localparam int DEPTH = 4;
    localparam int BT    = 64;   // cycles per bit at divisor 3

    logic PCLK = 1'b0;
    logic PRESETN = 1'b1;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    logic RX_line, TX, TXRDY, RXRDY, IRQ;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] sb[$];
    bit         txq[$];
    logic [7:0] rd;
    logic [7:0] exp_irqen;
    logic       exp_irq;
    int         c0, n, lows;

    uart_apb_fifo_if apb();

    uart_apb_fifo #(.FIFO_DEPTH(DEPTH), .RST_BAUD(13'd0)) dut (
        .PCLK   (PCLK),
        .PRESETN(PRESETN),
        .apb    (apb),
        .RX     (RX_line),
        .TX     (TX),
        .TXRDY  (TXRDY),
        .RXRDY  (RXRDY),
        .IRQ    (IRQ)
    );

    assign RX_line = loop_en ? TX : rx_drv;

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [2:0] r, input logic [7:0] d);
        @(posedge PCLK); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = {r, 2'b00}; apb.PWDATA = d;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] r, output logic [7:0] d);
        @(posedge PCLK); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = {r, 2'b00};
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        d = apb.PRDATA;
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] d, input bit pen, input bit par, input bit stopv);
        rx_drv = 1'b0;
        repeat (BT) @(posedge PCLK);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BT) @(posedge PCLK);
        end
        if (pen) begin
            rx_drv = par;
            repeat (BT) @(posedge PCLK);
        end
        rx_drv = stopv;
        repeat (BT) @(posedge PCLK);
        rx_drv = 1'b1;
        repeat (BT) @(posedge PCLK);
    endtask

    task automatic wait_rxrdy(input string tag);
        int k = 0;
        while (RXRDY !== 1'b1 && k < 2000) begin
            @(posedge PCLK); #1;
            k++;
        end
        check(tag, 32'(RXRDY), 32'd1);
    endtask

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = 5'd0; apb.PWDATA = 8'h00;
`ifdef UART_APB_FIFO_IRQ_EN
        exp_irqen = 8'h01; exp_irq = 1'b1;
`else
        exp_irqen = 8'h00; exp_irq = 1'b0;
`endif
        #2 PRESETN = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_txrdy", 32'(TXRDY), 32'd1);
        check("rst_rxrdy", 32'(RXRDY), 32'd0);
        check("rst_irq", 32'(IRQ), 32'd0);
        check("rst_prdata", 32'(apb.PRDATA), 32'h00);
        PRESETN = 1'b1;
        apb_read(3'd4, rd); check("rst_status", 32'(rd), 32'h21);
        apb_read(3'd5, rd); check("rst_level", 32'(rd), 32'h00);
        apb_read(3'd3, rd); check("rst_ctrl", 32'(rd), 32'h00);
        apb_read(3'd7, rd); check("unmapped_rd", 32'(rd), 32'h00);

        // Divisor 0, no parity: 0xA5 frame
        apb_write(3'd2, 8'h00);
        apb_write(3'd0, 8'hA5);
        txq.push_back(1'b0);
        for (int i = 0; i < 8; i++) txq.push_back(1'(8'hA5 >> i));
        txq.push_back(1'b1);
        n = 0;
        while (TX !== 1'b0 && n < 40) begin @(posedge PCLK); #1; n++; end
        check("tx_start_seen", 32'(TX), 32'd0);
        c0 = cyc;
        for (int b = 0; b < 10; b++) begin
            while (cyc < c0 + 16 * b + 8) begin @(posedge PCLK); #1; end
            check("tx_bit", 32'(TX), 32'(txq.pop_front()));
        end
        while (cyc < c0 + 170) begin @(posedge PCLK); #1; end
        apb_read(3'd4, rd); check("tx_empty_status", 32'(rd), 32'h21);

        // Loopback, odd parity, divisor 3
        apb_write(3'd3, 8'h03);
        apb_write(3'd2, 8'h03);
        loop_en = 1'b1;
        apb_write(3'd0, 8'h3C);
        sb.push_back(8'h3C);
        wait_rxrdy("loop_rxrdy");
        apb_read(3'd5, rd); check("loop_level1", 32'(rd), 32'd1);
        apb_read(3'd1, rd); check("loop_rxdata", 32'(rd), 32'(sb.pop_front()));
        apb_read(3'd1, rd); check("empty_rd_hold", 32'(rd), 32'h3C);
        apb_read(3'd4, rd); check("loop_par_err", 32'(rd & 8'h06), 32'h00);
        apb_read(3'd5, rd); check("loop_level0", 32'(rd), 32'd0);
        repeat (100) @(posedge PCLK);
        #1 loop_en = 1'b0;

        // RX overflow with a 4-deep FIFO
        apb_write(3'd3, 8'h00);
        for (int i = 0; i < 5; i++) begin
            rd = 8'(8'h31 * (i + 1));
            if (sb.size() < DEPTH) sb.push_back(rd);
            rx_send(rd, 1'b0, 1'b0, 1'b1);
        end
        apb_read(3'd4, rd); check("rx_overflow", 32'(rd & 8'h08), 32'h08);
        apb_read(3'd5, rd); check("rx_level_full", 32'(rd), 32'd4);
        while (sb.size() > 0) begin
            apb_read(3'd1, rd); check("rx_order", 32'(rd), 32'(sb.pop_front()));
        end
        check("rx_drained", 32'(RXRDY), 32'd0);
        apb_write(3'd4, 8'h08);
        apb_read(3'd4, rd); check("ovf_cleared", 32'(rd & 8'h08), 32'h00);

        // Framing error and W1C
        rx_send(8'h96, 1'b0, 1'b0, 1'b0);
        sb.push_back(8'h96);
        apb_read(3'd4, rd); check("frm_err_set", 32'(rd & 8'h10), 32'h10);
        apb_read(3'd1, rd); check("frm_byte", 32'(rd), 32'(sb.pop_front()));
        apb_write(3'd4, 8'h10);
        apb_read(3'd4, rd); check("frm_err_clr", 32'(rd & 8'h10), 32'h00);

        // Even parity expected, odd-parity bit sent
        apb_write(3'd3, 8'h01);
        rx_send(8'h5A, 1'b1, 1'b1, 1'b1);
        sb.push_back(8'h5A);
        apb_read(3'd4, rd); check("par_err_set", 32'(rd & 8'h04), 32'h04);
        apb_read(3'd1, rd); check("par_byte", 32'(rd), 32'(sb.pop_front()));
        apb_write(3'd4, 8'h04);
        apb_read(3'd4, rd); check("par_err_clr", 32'(rd & 8'h04), 32'h00);

        // Interrupt on RXRDY
        apb_write(3'd3, 8'h00);
        apb_write(3'd6, 8'h01);
        apb_read(3'd6, rd); check("irqen_rd", 32'(rd), 32'(exp_irqen));
        sb.push_back(8'hC3);
        fork
            rx_send(8'hC3, 1'b0, 1'b0, 1'b1);
            begin
                wait_rxrdy("irq_rxrdy");
                check("irq_same_cycle", 32'(IRQ), 32'd0);
                @(posedge PCLK); #1;
                check("irq_next_cycle", 32'(IRQ), 32'(exp_irq));
            end
        join
        apb_read(3'd1, rd); check("irq_byte", 32'(rd), 32'(sb.pop_front()));
        apb_write(3'd6, 8'h00);

        // TX FIFO full: push aligned with engine pop, then push while full
        apb_write(3'd2, 8'h00);
        apb_write(3'd0, 8'h11);
        n = 0;
        while (TX !== 1'b0 && n < 40) begin @(posedge PCLK); #1; n++; end
        check("tx2_start_seen", 32'(TX), 32'd0);
        c0 = cyc;
        for (int i = 0; i < DEPTH; i++) apb_write(3'd0, 8'(8'h20 + i));
        check("tx_full_txrdy", 32'(TXRDY), 32'd0);
        while (cyc < c0 + 157) begin @(posedge PCLK); #1; end
        apb_write(3'd0, 8'h77);
        apb_read(3'd4, rd); check("tx_ovf_pop_push", 32'(rd & 8'h40), 32'h00);
        check("tx_still_full", 32'(TXRDY), 32'd0);
        apb_write(3'd0, 8'h78);
        apb_read(3'd4, rd); check("tx_ovf_set", 32'(rd & 8'h40), 32'h40);

        // Reset mid-frame
        repeat (20) @(posedge PCLK);
        #3 PRESETN = 1'b0;
        #1;
        check("midrst_tx", 32'(TX), 32'd1);
        check("midrst_txrdy", 32'(TXRDY), 32'd1);
        check("midrst_prdata", 32'(apb.PRDATA), 32'h00);
        check("midrst_irq", 32'(IRQ), 32'd0);
        repeat (2) @(posedge PCLK);
        #1 PRESETN = 1'b1;
        lows = 0;
        repeat (400) begin
            @(posedge PCLK); #1;
            if (TX !== 1'b1) lows++;
        end
        check("no_frame_after_rst", 32'(lows), 32'd0);
        apb_read(3'd4, rd); check("post_rst_status", 32'(rd), 32'h21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
